key_sched_ctrl: RTL and testbench
=================================

// Module: key_sched_ctrl
// PURPOSE
//  - Serial AES-128 key-expansion sequencer. Accepts a cipher key and emits round keys rk0..rkNR
//    one at a time over a valid/ready stream.
//  - Time-shares a single sbox instance across the four bytes of RotWord(w3). SubWord therefore
//    costs 4 cycles instead of 4 parallel sboxes.
//  - Sits between the key-load interface and the round datapath of the cipher.
// PARAMETERS
//  - NR  default 10  number of rounds after rk0; legal range 1..10, bounded by the Rcon table.
// PORTS
//  - clk        in   1    single clock, rising edge.
//  - rst        in   1    asynchronous, active-high reset.
//  - key_in     in   128  cipher key; w0 = key_in[127:96], byte 0 of a word = its MSB byte (FIPS-197 order).
//  - key_valid  in   1    key_in is valid.
//  - key_ready  out  1    controller is IDLE and will accept a key.
//  - rk_out     out  128  current round key {w0,w1,w2,w3}.
//  - rk_idx     out  4    round index of rk_out, 0..NR.
//  - rk_valid   out  1    rk_out/rk_idx are valid.
//  - rk_ready   in   1    consumer accepts the round key.
//  - busy       out  1    high in every state except IDLE.
// BEHAVIOUR
//  - FSM states: IDLE, EMIT, SUB, MIX. All state is registered.
//  - Reset: async to IDLE. rk_out=0, rk_idx=0, rk_valid=0, busy=0, byte counter=0, w[0..3]=0.
//    key_ready = (state==IDLE), so it reads 1 after reset.
//  - IDLE: on key_valid&key_ready, load w0..w3 from key_in, set round=0, go to EMIT.
//  - EMIT: rk_valid=1, rk_out={w0..w3}, rk_idx=round.
//    - Held stable until rk_ready.
//    - On handshake with round==NR, go to IDLE; otherwise go to SUB with byte=0.
//  - SUB: sbox input is byte b of rot = {w3.b1,w3.b2,w3.b3,w3.b0}; result is registered into tmp.b.
//    b increments each cycle; at b==3 go to MIX.
//  - MIX (1 cycle):
//    - tmp.b0 ^= Rcon[round+1] (01,02,04,08,10,20,40,80,1b,36).
//    - w0'=w0^tmp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
//    - round++, go to EMIT.
//  - Latency: rk0 valid 1 cycle after the key handshake. With rk_ready held high, successive keys
//    are 6 cycles apart (EMIT+4 SUB+MIX). rk10 is valid 61 cycles after key accept; IDLE at +62.
//  - key_valid while busy: ignored (key_ready=0); no state change.
//  - rk_ready low in EMIT: stall indefinitely; rk_out, rk_idx and rk_valid stay constant.
//  - rk_ready outside EMIT: ignored.
//  - Reset mid-operation: immediate abort to the reset values. No partial key is emitted afterwards.
//  - All XORs are bytewise, 8-bit wide. Rcon lookup is indexed with round+1 in 4 bits.
// CONFIGURATION
//  - KEY_SCHED_PAR_SBOX_EN defined:
//    - Four sbox instances; SUB lasts 1 cycle and substitutes all four bytes at once.
//    - Key period becomes 3 cycles; rk10 is valid 31 cycles after key accept.
//  - KEY_SCHED_PAR_SBOX_EN undefined: one shared sbox and 4-cycle SUB, as described above.
//  - Port list and handshake rules are identical in both builds.
// STRUCTURE
//  - Shared defs header holds:
//    - state encoding localparams (IDLE/EMIT/SUB/MIX);
//    - the Rcon table constant and function;
//    - a byte/word type width of 8/32.
//  - Sub-module: existing sbox (lhs/o, 8-bit, combinational), instantiated once, or four times with
//    the macro. No new sub-modules.
// TESTING
//  - FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
//    - rk0 = key;
//    - rk1 = a0fafe1788542cb123a339392a6c7605;
//    - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
//    - rk_idx runs 0..10, spacing 6 cycles.
//  - All-zero key: rk1 = 62636363626363636263636362636363; 11 handshakes, then key_ready=1.
//  - Backpressure: random rk_ready (~30% high) -> rk_out stable while stalled; same 11 keys as the
//    rk_ready=1 run.
//  - key_valid pulsed during round 4 with a different key -> ignored; sequence completes for the
//    first key.
//  - rst asserted in SUB of round 6 -> outputs at reset values the same cycle. A new key then gives
//    correct rk0 after 1 cycle.
//  - With KEY_SCHED_PAR_SBOX_EN: the A.1 vector gives identical keys at 3-cycle spacing; rk10 at
//    cycle 31.

Source files
------------

// File: rtl/key_sched_ctrl_pkg.sv
// Purpose: shared types, FSM encoding, Rcon table and word helpers for the AES-128 key sequencer.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package key_sched_ctrl_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;

    // Round key as four words, w0 in the MSBs (FIPS-197 order).
    typedef struct packed {
        word_t w0;
        word_t w1;
        word_t w2;
        word_t w3;
    } rk_t;

    // Legacy-compatible state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_SUB  = 2'd2;
    localparam logic [1:0] ST_MIX  = 2'd3;

    // Rcon[1..10]; entry 0 of the table is Rcon[1].
    localparam logic [0:9][7:0] RCON_TBL = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Rcon lookup indexed by round+1; indices outside 1..10 give zero.
    function automatic byte_t rcon(input logic [3:0] idx);
        byte_t r;
        r = '0;
        if (idx >= 4'd1 && idx <= 4'd10) begin
            r = RCON_TBL[idx - 4'd1];
        end
        return r;
    endfunction

    // RotWord: {b1,b2,b3,b0} where b0 is the MSB byte.
    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Byte b of a word, byte 0 being the MSB byte.
    function automatic byte_t word_byte(input word_t w, input logic [1:0] b);
        byte_t r;
        case (b)
            2'd0:    r = w[31:24];
            2'd1:    r = w[23:16];
            2'd2:    r = w[15:8];
            default: r = w[7:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_sched_ctrl_sbox.sv
// Purpose: AES forward S-box, one byte in, one byte out.
// Latency: combinational (0 cycles).
// Backpressure: none; pure lookup.
module key_sched_ctrl_sbox
    import key_sched_ctrl_pkg::*;
(
    input  logic [7:0] lhs,
    output logic [7:0] o
);

    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o = SBOX_TBL[lhs];

endmodule

// File: rtl/key_sched_ctrl.sv
// Purpose: serial AES-128 key expansion, emits rk0..rkNR over a valid/ready stream (KEY_SCHED_PAR_SBOX_EN selects 4 parallel sboxes).
// Latency: rk0 one cycle after key accept; key period 6 cycles (3 with KEY_SCHED_PAR_SBOX_EN).
// Backpressure: EMIT holds rk_out/rk_idx/rk_valid until rk_ready; key_ready only in IDLE.
module key_sched_ctrl
    import key_sched_ctrl_pkg::*;
#(
    parameter int unsigned NR = 10
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
);

    localparam logic [3:0] NR_L = 4'(NR);

    logic [1:0] state;
    logic [3:0] round;
    rk_t        w;
    rk_t        w_next;
    word_t      tmp;
    word_t      rot;
    word_t      tmp_rc;
    logic [3:0] rcon_idx;
    logic       sub_last;

    assign rot       = rot_word(w.w3);
    assign rcon_idx  = round + 4'd1;

    assign key_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rk_valid  = (state == ST_EMIT);
    assign rk_out    = w;
    assign rk_idx    = round;

`ifdef KEY_SCHED_PAR_SBOX_EN
    word_t sub_all;

    // All four rotated bytes substituted in one cycle.
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        key_sched_ctrl_sbox u_sbox (
            .lhs (rot[8*g +: 8]),
            .o   (sub_all[8*g +: 8])
        );
    end

    assign sub_last = 1'b1;

    // Capture the substituted word during the single SUB cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmp <= '0;
        end else if (state == ST_SUB) begin
            tmp <= sub_all;
        end
    end
`else
    logic [1:0] byte_cnt;
    byte_t      sbox_in;
    byte_t      sbox_out;

    // One sbox walks the rotated word a byte per cycle, MSB byte first.
    assign sbox_in  = word_byte(rot, byte_cnt);
    assign sub_last = (byte_cnt == 2'd3);

    key_sched_ctrl_sbox u_sbox (
        .lhs (sbox_in),
        .o   (sbox_out)
    );

    // Byte counter and per-byte capture of the substituted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            tmp      <= '0;
        end else if (state == ST_SUB) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    tmp[31:24] <= sbox_out;
                2'd1:    tmp[23:16] <= sbox_out;
                2'd2:    tmp[15:8]  <= sbox_out;
                default: tmp[7:0]   <= sbox_out;
            endcase
        end else begin
            byte_cnt <= '0;
        end
    end
`endif

    // Next round key: Rcon folded into the MSB byte, then the XOR chain w0..w3.
    always_comb begin
        tmp_rc    = tmp ^ {rcon(rcon_idx), 24'h000000};
        w_next.w0 = w.w0 ^ tmp_rc;
        w_next.w1 = w.w1 ^ w_next.w0;
        w_next.w2 = w.w2 ^ w_next.w1;
        w_next.w3 = w.w3 ^ w_next.w2;
    end

    // Sequencer: load key, emit, substitute, mix, repeat until round NR is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            round <= '0;
            w     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_valid) begin
                        w     <= key_in;
                        round <= '0;
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rk_ready) begin
                        state <= (round == NR_L) ? ST_IDLE : ST_SUB;
                    end
                end
                ST_SUB: begin
                    if (sub_last) begin
                        state <= ST_MIX;
                    end
                end
                default: begin
                    w     <= w_next;
                    round <= round + 4'd1;
                    state <= ST_EMIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Purpose: self-checking bench for key_sched_ctrl against an arithmetic AES-128 key-expansion model.
// Latency: checks rk0 at one cycle after accept and fixed key spacing with rk_ready held high.
// Backpressure: random rk_ready exercises EMIT stalls; key_valid while busy must be ignored.
module tb_key_sched_ctrl;

`ifdef KEY_SCHED_PAR_SBOX_EN
    localparam int PERIOD = 3;
`else
    localparam int PERIOD = 6;
`endif
    localparam int NR = 10;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;

    int checks = 0;
    int failures = 0;

    logic [127:0] exp_rk [0:NR];
    logic [127:0] got_rk [0:NR];

    key_sched_ctrl #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    // S-box from first principles: multiplicative inverse (a^254) then the affine map.
    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] base;
        logic [7:0] e;
        logic [7:0] s;
        inv  = 8'h01;
        base = a;
        e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        s = inv;
        for (int i = 0; i < 4; i++) begin
            inv = rotl8(inv);
            s   = s ^ inv;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] ref_subword(input logic [31:0] x);
        return {ref_sbox(x[31:24]), ref_sbox(x[23:16]), ref_sbox(x[15:8]), ref_sbox(x[7:0])};
    endfunction

    // Textbook FIPS-197 expansion over a flat word array.
    task automatic build_ref(input logic [127:0] key);
        logic [31:0] wl [0:4*NR+3];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) wl[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 4*NR + 4; i++) begin
            t = wl[i-1];
            if (i % 4 == 0) begin
                t  = ref_subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            wl[i] = wl[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) exp_rk[r] = {wl[4*r], wl[4*r+1], wl[4*r+2], wl[4*r+3]};
    endtask

    function automatic logic pick(input int pct);
        return ($urandom_range(99, 0) < pct);
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one full key from IDLE; called and returning on a falling edge.
    task automatic run_seq(input logic [127:0] key, input int pct, input bit strict,
                           input bit inject, input string tag);
        int cyc;
        int idx;
        bit seen;
        build_ref(key);
        chk({tag, "_idle_ready"}, key_ready, 1'b1);
        key_in    = key;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_in    = rand_key();
        cyc  = 1;
        idx  = 0;
        seen = 0;
        while (idx <= NR && cyc < 3000) begin
            if (strict) chk({tag, "_vld_timing"}, rk_valid, ((cyc % PERIOD) == 1));
            if (rk_valid) begin
                chk({tag, "_idx"}, rk_idx, idx);
                chk({tag, "_rk"}, rk_out, exp_rk[idx]);
                if (!seen) begin
                    got_rk[idx] = rk_out;
                    seen = 1;
                    if (strict) chk({tag, "_spacing"}, cyc, 1 + idx*PERIOD);
                end
            end
            if (inject && idx == 4) begin
                chk({tag, "_busy_ready"}, key_ready, 1'b0);
                key_valid = 1'b1;
                key_in    = rand_key();
            end else begin
                key_valid = 1'b0;
            end
            rk_ready = strict ? 1'b1 : pick(pct);
            if (rk_valid && rk_ready) begin
                idx++;
                seen = 0;
            end
            @(negedge clk);
            cyc++;
        end
        key_valid = 1'b0;
        chk({tag, "_all_keys"}, idx, NR + 1);
        chk({tag, "_end_ready"}, key_ready, 1'b1);
        chk({tag, "_end_busy"}, busy, 1'b0);
        chk({tag, "_end_vld"}, rk_valid, 1'b0);
        if (strict) chk({tag, "_end_cycle"}, cyc, NR*PERIOD + 2);
    endtask

    initial begin
        logic [127:0] k;
        int guard;

        rst       = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        #1;
        chk("rst_key_ready", key_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rk_valid", rk_valid, 1'b0);
        chk("rst_rk_out", rk_out, '0);
        chk("rst_rk_idx", rk_idx, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", key_ready, 1'b1);

        // FIPS-197 A.1 with rk_ready held high
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        run_seq(k, 100, 1'b1, 1'b0, "a1");
        chk("a1_rk0", got_rk[0], k);
        chk("a1_rk1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("a1_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // All-zero key
        run_seq('0, 100, 1'b1, 1'b0, "zero");
        chk("zero_rk1", got_rk[1], 128'h62636363626363636263636362636363);

        // Backpressure on the A.1 key and random keys, one with a key pulse while busy
        run_seq(k, 30, 1'b0, 1'b0, "a1_bp");
        chk("a1_bp_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run_seq(rand_key(), 30, 1'b0, 1'b1, "inject");
        run_seq(rand_key(), 30, 1'b0, 1'b0, "rand_a");
        run_seq(rand_key(), 100, 1'b1, 1'b0, "rand_b");

        // Reset in SUB of round 6
        k = rand_key();
        key_in    = k;
        key_valid = 1'b1;
        rk_ready  = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        guard = 0;
        while (!(rk_valid && rk_idx == 4'd6) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_reach_rk6", (guard < 200), 1'b1);
        @(negedge clk);
        chk("abort_in_sub_busy", busy, 1'b1);
        chk("abort_in_sub_vld", rk_valid, 1'b0);
        rst = 1'b1;
        #1;
        chk("abort_rk_out", rk_out, '0);
        chk("abort_rk_idx", rk_idx, '0);
        chk("abort_rk_valid", rk_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_key_ready", key_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_partial", rk_valid, 1'b0);
        end
        run_seq(rand_key(), 100, 1'b1, 1'b0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
